// File: rtl/blood_sw_debounce.sv
// Switch conditioning for the blood-type checker: 2-flop sync plus a
// per-bit saturating-count debouncer, with a registered change strobe and mask.

module blood_sw_debounce_bit #(
    parameter int CNT_MAX = 1_000_000,
    parameter int CNT_W   = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic stb,
    output logic upd
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             s1, s2;
    logic [CNT_W-1:0] cnt;
    logic             at_last;

    assign at_last = (cnt == CNT_LAST);
    // Combinational so the top can register it on the same edge that moves stb.
    assign upd     = (s2 != stb) && at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            stb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            if (s2 == stb) begin
                cnt <= '0;
            end else if (at_last) begin
                stb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module blood_sw_debounce #(
    parameter int N       = 8,
    parameter int CNT_MAX = 1_000_000,
    parameter int CNT_W   = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw_pin,
    output logic [N-1:0] sw_stable,
    output logic         sw_change,
    output logic [N-1:0] sw_changed_mask
);
    logic [N-1:0] upd;

    for (genvar g = 0; g < N; g++) begin : g_bit
        blood_sw_debounce_bit #(
            .CNT_MAX (CNT_MAX),
            .CNT_W   (CNT_W)
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .pin (sw_pin[g]),
            .stb (sw_stable[g]),
            .upd (upd[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_change       <= 1'b0;
            sw_changed_mask <= '0;
        end else begin
            sw_change       <= |upd;
            sw_changed_mask <= upd;
        end
    end
endmodule
